// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl -- issue controller for an LC-3 style ADD/AND/NOT subset.
//
// An instruction is accepted in IDLE, its operands are read from an 8-entry
// register file and driven to an external combinational ALU for one EXEC
// cycle, and the ALU result is written back in the following WB cycle.
// Throughput is one instruction per three cycles.
//
// Optional feature: define ALU_ISSUE_NZP_EN to implement the {N,Z,P}
// condition-code register. Without it the nzp port is tied to 3'b000.
//
// Ports:
//   Clk          rising-edge clock
//   Reset_n      synchronous active-low reset
//   instr_valid  instruction offered this cycle
//   instr        16-bit instruction word
//   instr_ready  high in IDLE, instruction can be accepted
//   alu_A/alu_B  operands to the external ALU (zero outside EXEC)
//   alu_select   ALU op: 00 ADD, 01 AND, 10 NOT, 11 PASS_A
//   alu_out      combinational ALU result
//   done         one-cycle writeback pulse
//   illegal      one-cycle pulse for a discarded unsupported opcode
//   wb_reg       destination register (zero unless done)
//   wb_data      written value (zero unless done)
//   nzp          condition codes {N,Z,P}
//   dbg_addr     debug register-file read index
//   dbg_data     combinational RF[dbg_addr]
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [1:0]       alu_select,
  input  logic [WIDTH-1:0] alu_out,
  output logic             done,
  output logic             illegal,
  output logic [2:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data,
  output logic [2:0]       nzp,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e           state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rf_q [8];
  logic [WIDTH-1:0] rf_d [8];

  // Decode of the captured instruction
  logic [3:0]       opcode;
  logic [2:0]       dr, sr1, sr2;
  logic [WIDTH-1:0] imm_sext;
  logic             op_legal;
  logic             op_not;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] operand_b;

  assign opcode   = instr_q[15:12];
  assign dr       = instr_q[11:9];
  assign sr1      = instr_q[8:6];
  assign sr2      = instr_q[2:0];
  assign imm_sext = {{(WIDTH-5){instr_q[4]}}, instr_q[4:0]};

  always_comb begin
    op_legal = 1'b1;
    op_not   = 1'b0;
    op_sel   = 2'b11;
    case (opcode)
      4'b0001: op_sel = 2'b00;
      4'b0101: op_sel = 2'b01;
      4'b1001: begin
        op_sel = 2'b10;
        op_not = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    operand_b = '0;
    if (!op_not) begin
      operand_b = instr_q[5] ? imm_sext : rf_q[sr2];
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    instr_ready = 1'b0;
    alu_A       = '0;
    alu_B       = '0;
    alu_select  = 2'b11;
    done        = 1'b0;
    illegal     = 1'b0;
    wb_reg      = '0;
    wb_data     = '0;
    unique case (state_q)
      StIdle: instr_ready = 1'b1;
      StExec: begin
        alu_select = op_sel;
        // An unsupported opcode only passes zero through the ALU
        if (op_legal) begin
          alu_A = rf_q[sr1];
          alu_B = operand_b;
        end
      end
      StWb: begin
        if (op_legal) begin
          done    = 1'b1;
          wb_reg  = dr;
          wb_data = result_q;
        end else begin
          illegal = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    instr_d  = instr_q;
    result_d = result_q;
    rf_d     = rf_q;
    if (state_q == StIdle && instr_valid) begin
      instr_d = instr;
    end
    if (state_q == StExec) begin
      result_d = alu_out;
    end
    if (state_q == StWb && op_legal) begin
      rf_d[dr] = result_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      instr_q  <= '0;
      result_q <= '0;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      instr_q  <= instr_d;
      result_q <= result_d;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign dbg_data = rf_q[dbg_addr];

`ifdef ALU_ISSUE_NZP_EN
  logic [2:0] nzp_q, nzp_d;

  always_comb begin
    nzp_d = nzp_q;
    if (state_q == StWb && op_legal) begin
      if (result_q[WIDTH-1]) begin
        nzp_d = 3'b100;
      end else if (result_q == '0) begin
        nzp_d = 3'b010;
      end else begin
        nzp_d = 3'b001;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      nzp_q <= 3'b010;
    end else begin
      nzp_q <= nzp_d;
    end
  end

  assign nzp = nzp_q;
`else
  assign nzp = 3'b000;
`endif

endmodule
